// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// digit count, all-off patterns and active-low hex segment codes {g,f,e,d,c,b,a}.
package seg_pkg;
  localparam int         DIGITS  = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver: per-frame shadow of the data word,
// per-slot blanking window, optional leading-zero suppression, registered outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int BLANK   = 16
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [31:0] data,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic          wrap;
  logic          in_blank;
  logic          lz;
  logic [3:0]    nibble;
  logic [6:0]    hex_seg;

  assign wrap   = (cnt == CW'(CLK_DIV - 1));
  assign nibble = shadow[{idx, 2'b00} +: 4];

  // Leading zero: every nibble from this digit upward is zero; digit 0 always shows.
  assign lz = blank_lz && (idx != 3'd0) && ((shadow >> {idx, 2'b00}) == 32'd0);

  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK));
    end
  endgenerate

  seg_hex_decode u_hex (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (wrap) begin
        cnt <= '0;
        idx <= idx + 3'd1;
        if (idx == 3'(DIGITS - 1)) begin
          shadow     <= data;
          frame_tick <= 1'b1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (in_blank) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << idx);
      seg <= lz ? SEG_OFF : hex_seg;
      dp  <= ~dp_mask[idx];
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with CLK_DIV=4, BLANK=1: walks whole frames slot by slot.
module tb_seg_scan_driver;
  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic [31:0] data = 32'h0;
  logic        blank_lz = 1'b0;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  seg_scan_driver #(.CLK_DIV(4), .BLANK(1)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .data       (data),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 CLK = ~CLK;

  // Segment codes per digit 0..7 for data 32'h12345678.
  logic [6:0] codes_1234 [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One slot: blank cycle then three digit cycles; frame_tick expected only on the last one.
  task automatic slot(input string tag, input int d, input logic [6:0] seg_e,
                      input logic dp_e, input logic ft_e);
    logic [7:0] an_e;
    an_e = ~(8'b1 << d);
    @(posedge CLK); #1;
    chk({tag, "_blank_an"}, an, 8'hFF);
    chk({tag, "_blank_seg"}, {1'b0, seg}, 8'h7F);
    chk({tag, "_blank_dp"}, {7'b0, dp}, 8'h01);
    chk({tag, "_blank_ft"}, {7'b0, frame_tick}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk({tag, "_an"}, an, an_e);
      chk({tag, "_seg"}, {1'b0, seg}, {1'b0, seg_e});
      chk({tag, "_dp"}, {7'b0, dp}, {7'b0, dp_e});
      chk({tag, "_ft"}, {7'b0, frame_tick}, {7'b0, (i == 2) ? ft_e : 1'b0});
    end
  endtask

  initial begin
    data = 32'h12345678;
    #12;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'b0, dp}, 8'h01);
    chk("rst_ft", {7'b0, frame_tick}, 8'h00);
    @(negedge CLK);
    RST_n = 1'b1;

    // Frame 0: shadow still zero.
    for (int d = 0; d < 8; d++) slot("f0", d, 7'h40, 1'b1, d == 7);
    // Frame 1: 12345678; load A0 for next frame after digit 0.
    for (int d = 0; d < 8; d++) begin
      slot("f1", d, codes_1234[d], 1'b1, d == 7);
      if (d == 0) data = 32'h0000_00A0;
    end
    blank_lz = 1'b1;
    // Frame 2: A0 with leading-zero suppression.
    for (int d = 0; d < 8; d++) begin
      slot("f2", d, (d == 0) ? 7'h40 : (d == 1) ? 7'h08 : 7'h7F, 1'b1, d == 7);
      if (d == 0) data = 32'h0;
    end
    // Frame 3: all zero, only digit 0 lit.
    for (int d = 0; d < 8; d++) begin
      slot("f3", d, (d == 0) ? 7'h40 : 7'h7F, 1'b1, d == 7);
      if (d == 0) data = 32'hFFFF_FFFF;
    end
    blank_lz = 1'b0;
    // Frame 4: all F; data drops to zero once idx reaches 3, must not tear.
    for (int d = 0; d < 8; d++) begin
      slot("f4", d, 7'h0E, 1'b1, d == 7);
      if (d == 2) data = 32'h0;
    end
    // Frame 5: zeros appear only now.
    slot("f5", 0, 7'h40, 1'b1, 1'b0);
    slot("f5", 1, 7'h40, 1'b1, 1'b0);

    // Asynchronous reset mid-slot, away from any clock edge.
    data = 32'h12345678;
    @(posedge CLK); #3;
    RST_n = 1'b0;
    #1;
    chk("arst_an", an, 8'hFF);
    chk("arst_seg", {1'b0, seg}, 8'h7F);
    chk("arst_dp", {7'b0, dp}, 8'h01);
    chk("arst_ft", {7'b0, frame_tick}, 8'h00);
    @(posedge CLK); #1;
    chk("arst_hold_an", an, 8'hFF);
    dp_mask = 8'h04;
    @(negedge CLK);
    RST_n = 1'b1;

    // Restart at digit 0 with shadow zero; dp lit only on digit 2.
    for (int d = 0; d < 8; d++) slot("r0", d, 7'h40, (d == 2) ? 1'b0 : 1'b1, d == 7);
    slot("r1", 0, 7'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
